// File: rtl/multu_unit.sv
// multu_unit: sequential shift-add WIDTHxWIDTH multiplier holding its product in HI/LO.
// Define MULTU_SIGNED_EN to add MULT (sign-magnitude around the unsigned core).
module multu_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             is_signed,
  input  logic             hi_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] prod_q, prod_d, res_d;
  logic [WIDTH-1:0]   mcand_q, hi_q, lo_q, a_d, b_d;
  logic [WIDTH:0]     sum_d;
  logic               busy_q, done_q, last_d;
  always_comb begin
    sum_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {sum_d, prod_q[WIDTH-1:1]};
    last_d = cnt_q == CNT_W'(WIDTH - 1);
  end
`ifdef MULTU_SIGNED_EN
  logic neg_q;
  always_comb begin
    a_d   = (is_signed && dataA[WIDTH-1]) ? -dataA : dataA;
    b_d   = (is_signed && dataB[WIDTH-1]) ? -dataB : dataB;
    res_d = neg_q ? -prod_d : prod_d;
  end
  always_ff @(posedge clk)
    if (rst) neg_q <= 1'b0;
    else if (start && state_q != RUN) neg_q <= is_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  always_comb begin
    a_d   = dataA;
    b_d   = dataB;
    res_d = prod_d;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == RUN) begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q + 1'b1;
        if (last_d) begin
          hi_q    <= res_d[2*WIDTH-1:WIDTH];
          lo_q    <= res_d[WIDTH-1:0];
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else if (start) begin
        mcand_q <= a_d;
        prod_q  <= {{WIDTH{1'b0}}, b_d};
        cnt_q   <= '0;
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign dataOut = hi_sel ? hi_q : lo_q;
endmodule

// File: doc/multu_unit.md
Name: multu_unit

Overview:
- Sequential 32x32 shift-add multiplier for the EX stage; runs beside the ALU on the same dataA/dataB operands.
- Holds the 64-bit product in an internal HI/LO register pair.
- Drives a 32-bit dataOut that the downstream EX result mux selects instead of the ALU's dataOut for MFHI/MFLO.
- Handles MULTU (and MULT when the optional feature is compiled in).

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits and the product register is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply of dataA x dataB; sampled only in IDLE or DONE
- dataA  input  WIDTH  multiplicand (rs)
- dataB  input  WIDTH  multiplier (rt)
- is_signed  input  1  signed multiply request; used only when MULTU_SIGNED_EN is defined, ignored otherwise
- hi_sel  input  1  1 selects HI onto dataOut, 0 selects LO (MFHI/MFLO)
- busy  output  1  high while an operation is running
- done  output  1  one-cycle pulse when HI/LO have been updated
- dataOut  output  WIDTH  hi_sel ? HI : LO, combinational from the registers

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, HI=0, LO=0, counter=0, product=0, busy=0, done=0, so dataOut=0.
  - rst overrides start and takes effect in any state; an in-flight multiply is abandoned and HI/LO are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: latch mcand=dataA; product={WIDTH'b0, dataB}; counter=0; go to RUN.
- RUN: busy=1, done=0. Each edge performs one step:
  - sum = {1'b0, product[2W-1:W]} + (product[0] ? mcand : 0), computed at WIDTH+1 bits so the carry is kept.
  - product = {sum, product[W-1:1]}, i.e. a logical right shift by 1 that keeps the carry.
  - counter increments.
  - On the edge where counter==WIDTH-1: write HI=product_next[2W-1:W] and LO=product_next[W-1:0], then go to DONE.
  - start is ignored while in RUN.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 at the edge: begin a new operation directly (same actions as IDLE); otherwise go to IDLE.
- Latency: start accepted at edge E; HI/LO update and the DONE entry occur at edge E+WIDTH (E+32 by default). done is high during the following cycle.
- HI/LO change only at the completion edge or on reset. dataOut shows the old product for the whole RUN period.
- dataOut follows hi_sel combinationally in every state, including RUN.
- Operands are captured at the start edge; changes to dataA/dataB during RUN have no effect.
- Arithmetic: unsigned with no overflow. 0xFFFFFFFF x 0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001.

Optional Feature:
- Macro: MULTU_SIGNED_EN
- Defined:
  - At start, if is_signed=1, latch |dataA| and |dataB| and store neg = dataA[W-1] ^ dataB[W-1].
  - At the completion edge, if neg=1, write the two's complement of the 64-bit product to {HI,LO}.
  - is_signed=0 behaves exactly as MULTU.
  - Latency is unchanged (WIDTH cycles).
  - -2^31 x -2^31 gives HI=0x40000000, LO=0.
- Not defined:
  - is_signed is unused; all operations are unsigned; no negation logic is present.

Test Plan:
- Reset then idle: rst for 2 cycles -> busy=0, done=0, dataOut=0 for hi_sel=0 and for hi_sel=1.
- Basic product: start with A=0x00000007, B=0x00000006 -> busy=1 for 32 cycles; done pulses once at edge start+32; hi_sel=0 gives 0x0000002A and hi_sel=1 gives 0.
- Full-range product: A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Change dataA mid-run to 0 -> result unaffected.
- Start ignored in RUN: start every cycle from the start edge through edge start+31, with A=0x00010000, B=0x00010000 -> exactly one done; HI=1, LO=0. Then start held at the DONE edge with A=3, B=5 -> new operation with no IDLE cycle; LO=15.
- Reset mid-run: after the first product completes, start a new multiply and assert rst at cycle 10 -> IDLE, HI=LO=0, no done pulse.
- With MULTU_SIGNED_EN defined: is_signed=1, A=0xFFFFFFFE (-2), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with is_signed=0 -> HI=0x00000002, LO=0xFFFFFFFA.
